dpd_lut_apply: RTL and testbench
================================

// Module: dpd_lut_apply
// PURPOSE
//  Consumer of the complex-magnitude LUT address in the DPD actuator datapath.
//  Delays each packed I/Q sample to align it with its magnitude address, then reads a complex
//  gain from a ping-pong coefficient LUT (BRAM) and applies out = tu * coef.
//  Host side writes the shadow bank and requests a bank swap.
//  The output is rounded and saturated to the input sample format.
// PARAMETERS
//  LUT_DATA_WIDTH  32  packed sample/coef width; I = upper half, Q = lower half, each signed
//  LUT_ADDR_WIDTH  10  LUT address width; depth per bank = 2**LUT_ADDR_WIDTH
//  MAG_LATENCY     16  cycles from tu to its matching mag; must be >= 1
//  COEF_FRAC       14  coef fractional bits; unity gain = 2**COEF_FRAC
// PORTS
//  clk           in   1    clock; all logic single clock domain
//  rst           in   1    synchronous, active-high reset
//  tu            in   LUT_DATA_WIDTH  input sample {I,Q}
//  tu_valid      in   1    tu qualifier
//  mag           in   LUT_ADDR_WIDTH  LUT address for the sample presented MAG_LATENCY cycles earlier
//  lut_enable    in   1    0: coef forced to unity (bypass); 1: LUT coef used
//  lut_wr_en     in   1    write strobe to shadow bank
//  lut_wr_addr   in   LUT_ADDR_WIDTH  write address
//  lut_wr_data   in   LUT_DATA_WIDTH  coef {ci,cq}, signed Q(16-COEF_FRAC).COEF_FRAC
//  lut_swap_req  in   1    one-cycle pulse: request active/shadow swap
//  lut_swap_done out  1    one-cycle pulse when swap has taken effect
//  lut_active    out  1    index of bank currently read by datapath
//  y             out  LUT_DATA_WIDTH  output sample {yi,yq}
//  y_valid       out  1    y qualifier
// BEHAVIOUR
//  Reset: y=0, y_valid=0, lut_active=0, lut_swap_done=0, swap FSM=IDLE, delay-line valids cleared.
//  Reset does not clear LUT RAM contents.
//  Alignment: tu/tu_valid shift through a MAG_LATENCY-deep register line.
//  At the line output, mag is sampled as the read address for that sample.
//  Pipeline after alignment:
//    S1: BRAM read from bank lut_active.
//    S2: four signed 16x16 products.
//    S3: yi_full = xi*ci - xq*cq; yq_full = xi*cq + xq*ci (33-bit).
//    S4: add 2**(COEF_FRAC-1), arithmetic shift right COEF_FRAC, saturate to [-32768, 32767].
//  Total latency tu -> y = MAG_LATENCY + 4 cycles.
//  y_valid = delayed tu_valid. Invalid samples still flow, but y_valid=0 for them.
//  Bank used for a sample is latched at S1 and travels with the sample; no sample mixes banks.
//  Bypass: lut_enable is sampled at S1; when 0, coef = {2**COEF_FRAC, 0}, so y == tu except for saturation.
//  Writes: when lut_wr_en=1, the shadow bank (~lut_active) is written at lut_wr_addr. Write latency is 1 cycle.
//  Datapath never reads the shadow bank.
//  Swap FSM:
//    IDLE -> PEND on lut_swap_req.
//    PEND stays while lut_wr_en=1, so a burst in progress completes into the old shadow bank.
//    PEND -> SWAP on first cycle lut_wr_en=0.
//    SWAP: lut_active toggles, lut_swap_done=1 for one cycle, -> IDLE.
//  lut_swap_req while in PEND or SWAP is ignored; no queuing.
//  lut_wr_en in the SWAP cycle targets the new shadow bank (post-toggle).
//  Reset mid-swap: FSM returns to IDLE, lut_active=0, and the pending request is lost.
// TESTING
//  T1 bypass:
//    lut_enable=0, tu={16'd1000,-16'd500}, valid 1 cycle.
//    -> y={1000,-500}, y_valid exactly MAG_LATENCY+4 cycles later.
//  T2 gain:
//    Write shadow bank[5]={16'd8192,0}, swap.
//    Then tu={16'd2000,16'd2000} with mag=5.
//    -> y={1000,1000}.
//  T3 rotation/saturation:
//    coef={0,16'd16384}, tu={16'd1,16'd0} -> y={0,1}.
//    coef={16'd32767,0}, tu={16'd32767,0} -> yi=32767 (saturated).
//  T4 rounding:
//    coef={16'd8192,0}, tu={16'd3,16'd0} -> yi=2.
//    tu={-16'd3,16'd0} -> yi=-1 (round half up).
//  T5 swap during write burst:
//    lut_swap_req mid-burst of 8 writes.
//    -> lut_swap_done pulses 1 cycle after the last write, lut_active toggles.
//    -> samples in flight before the toggle use the old bank.
//  T6 reset mid-operation:
//    Assert rst with samples in flight and FSM in PEND.
//    -> y_valid=0, y=0, lut_active=0, no swap_done afterward.
//    -> LUT contents preserved.

Source files
------------

// File: rtl/dpd_lut_apply_if.sv
// rtl/dpd_lut_apply_if.sv - sample stream and LUT host bus for dpd_lut_apply
//
// Purpose: groups the datapath stream (tu in, y out, aligned mag address) and
//          the coefficient host port (shadow-bank writes, bank swap) of dpd_lut_apply.
// Signals:
//   tu, tu_valid      input sample {I,Q} and qualifier
//   mag               LUT address for the sample presented MAG_LATENCY cycles earlier
//   lut_enable        0: unity coefficient (bypass), 1: LUT coefficient
//   lut_wr_en/addr/data  shadow bank write port
//   lut_swap_req      one-cycle request to swap active/shadow banks
//   lut_swap_done     one-cycle pulse when the swap has taken effect
//   lut_active        bank currently read by the datapath
//   y, y_valid        output sample {yi,yq} and qualifier
// Modports: master = sample/host source, slave = dpd_lut_apply.

interface dpd_lut_apply_if #(
   parameter int LUT_DATA_WIDTH = 32,
   parameter int LUT_ADDR_WIDTH = 10
);
   logic [LUT_DATA_WIDTH-1:0] tu;
   logic                      tu_valid;
   logic [LUT_ADDR_WIDTH-1:0] mag;
   logic                      lut_enable;
   logic                      lut_wr_en;
   logic [LUT_ADDR_WIDTH-1:0] lut_wr_addr;
   logic [LUT_DATA_WIDTH-1:0] lut_wr_data;
   logic                      lut_swap_req;
   logic                      lut_swap_done;
   logic                      lut_active;
   logic [LUT_DATA_WIDTH-1:0] y;
   logic                      y_valid;

   modport master (
      output tu, tu_valid, mag, lut_enable, lut_wr_en, lut_wr_addr, lut_wr_data, lut_swap_req,
      input  lut_swap_done, lut_active, y, y_valid
   );

   modport slave (
      input  tu, tu_valid, mag, lut_enable, lut_wr_en, lut_wr_addr, lut_wr_data, lut_swap_req,
      output lut_swap_done, lut_active, y, y_valid
   );
endinterface

// File: rtl/dpd_lut_apply.sv
// rtl/dpd_lut_apply.sv - DPD actuator: aligned ping-pong LUT complex gain
//
// Purpose: delays each {I,Q} sample by MAG_LATENCY cycles to meet its magnitude
//          address, reads a complex coefficient from the active bank of a
//          ping-pong LUT and outputs round/saturate(tu * coef).
//          tu -> y latency is MAG_LATENCY + 4 cycles.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset (LUT contents are kept)
//   bus  dpd_lut_apply_if.slave: tu/tu_valid/mag in, y/y_valid out,
//        lut_enable, shadow-bank write port, swap request/done, lut_active

module dpd_lut_apply #(
   parameter int LUT_DATA_WIDTH = 32,
   parameter int LUT_ADDR_WIDTH = 10,
   parameter int MAG_LATENCY    = 16,
   parameter int COEF_FRAC      = 14
) (
   input  logic           clk,
   input  logic           rst,
   dpd_lut_apply_if.slave bus
);
   localparam int W     = LUT_DATA_WIDTH;
   localparam int H     = LUT_DATA_WIDTH / 2;
   localparam int DEPTH = 2 ** LUT_ADDR_WIDTH;

   localparam logic [H-1:0]          COEF_ONE = H'(2 ** COEF_FRAC);
   localparam logic signed [2*H+1:0] RND      = (2*H+2)'(2 ** (COEF_FRAC - 1));
   localparam logic signed [2*H+1:0] SAT_MAX  = (2*H+2)'(2 ** (H - 1) - 1);
   localparam logic signed [2*H+1:0] SAT_MIN  = ~SAT_MAX;

   typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_SWAP} swap_state_t;

   swap_state_t swap_state;
   logic        lut_active;
   logic        swap_done;

   // Alignment line
   logic [W-1:0]           dl_data [MAG_LATENCY];
   logic [MAG_LATENCY-1:0] dl_valid;

   // Bank index is the MSB of the RAM address, so reads and writes never share a bank
   logic [W-1:0] mem [2*DEPTH];

   logic [W-1:0]          s1_x, s1_coef_raw, coef;
   logic                  s1_en, s1_valid, s2_valid, s3_valid;
   logic signed [H-1:0]   xi, xq, ci, cq;
   logic signed [2*H-1:0] s2_pii, s2_pqq, s2_piq, s2_pqi;
   logic signed [2*H:0]   s3_yi, s3_yq;
   logic signed [2*H+1:0] yi_sh, yq_sh;
   logic [W-1:0]          y;
   logic                  y_valid;

   assign bus.lut_active    = lut_active;
   assign bus.lut_swap_done = swap_done;
   assign bus.y             = y;
   assign bus.y_valid       = y_valid;

   function automatic logic [H-1:0] sat(input logic signed [2*H+1:0] v);
      logic [H-1:0] r;
      if (v > SAT_MAX)      r = SAT_MAX[H-1:0];
      else if (v < SAT_MIN) r = SAT_MIN[H-1:0];
      else                  r = v[H-1:0];
      return r;
   endfunction

   always_ff @(posedge clk) begin
      dl_data[0] <= bus.tu;
      for (int i = 1; i < MAG_LATENCY; i++) dl_data[i] <= dl_data[i-1];
      if (rst) begin
         dl_valid <= '0;
      end else begin
         dl_valid[0] <= bus.tu_valid;
         for (int i = 1; i < MAG_LATENCY; i++) dl_valid[i] <= dl_valid[i-1];
      end
   end

   // Writes always go to the shadow bank as seen in the current cycle; in the
   // SWAP cycle lut_active has already toggled, so they land in the new shadow.
   always_ff @(posedge clk) begin
      if (bus.lut_wr_en) mem[{~lut_active, bus.lut_wr_addr}] <= bus.lut_wr_data;
   end

   // S1: the read address picks the bank here, which is how the bank choice
   // travels with the sample through the rest of the pipeline.
   always_ff @(posedge clk) begin
      s1_coef_raw <= mem[{lut_active, bus.mag}];
   end

   always_comb begin
      coef = s1_en ? s1_coef_raw : {COEF_ONE, {H{1'b0}}};
      xi   = s1_x[W-1:H];
      xq   = s1_x[H-1:0];
      ci   = coef[W-1:H];
      cq   = coef[H-1:0];
      yi_sh = ((2*H+2)'(s3_yi) + RND) >>> COEF_FRAC;
      yq_sh = ((2*H+2)'(s3_yq) + RND) >>> COEF_FRAC;
   end

   always_ff @(posedge clk) begin
      s1_x   <= dl_data[MAG_LATENCY-1];
      s1_en  <= bus.lut_enable;
      s2_pii <= xi * ci;
      s2_pqq <= xq * cq;
      s2_piq <= xi * cq;
      s2_pqi <= xq * ci;
      s3_yi  <= (2*H+1)'(s2_pii) - (2*H+1)'(s2_pqq);
      s3_yq  <= (2*H+1)'(s2_piq) + (2*H+1)'(s2_pqi);
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
         y_valid  <= 1'b0;
         y        <= '0;
      end else begin
         s1_valid <= dl_valid[MAG_LATENCY-1];
         s2_valid <= s1_valid;
         s3_valid <= s2_valid;
         y_valid  <= s3_valid;
         y        <= {sat(yi_sh), sat(yq_sh)};
      end
   end

   // Swap FSM: a pending swap waits for the write burst to finish so the burst
   // completes into the bank it started in.
   always_ff @(posedge clk) begin
      if (rst) begin
         swap_state <= ST_IDLE;
         lut_active <= 1'b0;
         swap_done  <= 1'b0;
      end else begin
         swap_done <= 1'b0;
         case (swap_state)
            ST_IDLE: if (bus.lut_swap_req) swap_state <= ST_PEND;
            ST_PEND: if (!bus.lut_wr_en) begin
               swap_state <= ST_SWAP;
               lut_active <= ~lut_active;
               swap_done  <= 1'b1;
            end
            ST_SWAP: swap_state <= ST_IDLE;
            default: swap_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dpd_lut_apply.sv
// tb/tb_dpd_lut_apply.sv - randomized and directed checks of dpd_lut_apply

module tb_dpd_lut_apply;
   localparam int ML = 16;
   localparam int NC = 16384;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp  = 0;
   int   n_fail = 0;

   dpd_lut_apply_if #(.LUT_DATA_WIDTH(32), .LUT_ADDR_WIDTH(10)) bus ();

   dpd_lut_apply #(
      .LUT_DATA_WIDTH(32), .LUT_ADDR_WIDTH(10), .MAG_LATENCY(ML), .COEF_FRAC(14)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [15:0] clip(input longint v);
      longint q;
      q = v + 8192;
      q = (q >= 0) ? q / 16384 : -((-q + 16383) / 16384);
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      return q[15:0];
   endfunction

   function automatic logic [31:0] model_y(input logic [31:0] x, input logic [31:0] c);
      longint xi, xq, ci, cq;
      xi = longint'($signed(x[31:16]));
      xq = longint'($signed(x[15:0]));
      ci = longint'($signed(c[31:16]));
      cq = longint'($signed(c[15:0]));
      return {clip(xi * ci - xq * cq), clip(xi * cq + xq * ci)};
   endfunction

   logic [31:0] h_tu [NC];
   bit          h_v  [NC];
   logic [31:0] e_y  [NC];
   bit          e_v  [NC];
   logic [31:0] m_mem [2][1024];
   logic [31:0] m_coef;
   bit          m_active = 1'b0;
   bit          m_pend   = 1'b0;
   bit          m_done   = 1'b0;
   int          n = -1;

   // Edge n: sample taken at edge n meets its mag at edge n+ML, result visible after edge n+ML+3.
   always @(posedge clk) begin
      n++;
      h_tu[n] = bus.tu;
      h_v[n]  = bus.tu_valid && !rst;
      if (rst) begin
         for (int k = n - ML; k <= n; k++) if (k >= 0) h_v[k] = 1'b0;
         e_v[n] = 1'b0; e_v[n+1] = 1'b0; e_v[n+2] = 1'b0;
         m_active = 1'b0; m_pend = 1'b0; m_done = 1'b0;
      end else begin
         if (n >= ML && h_v[n-ML] && n + 3 < NC) begin
            m_coef = bus.lut_enable ? m_mem[m_active][bus.mag] : 32'h4000_0000;
            e_y[n+3] = model_y(h_tu[n-ML], m_coef);
            e_v[n+3] = 1'b1;
         end
         if (bus.lut_wr_en) m_mem[!m_active][bus.lut_wr_addr] = bus.lut_wr_data;
         if (m_pend && !bus.lut_wr_en) begin
            m_active = !m_active;
            m_pend   = 1'b0;
            m_done   = 1'b1;
         end else begin
            if (bus.lut_swap_req && !m_pend && !m_done) m_pend = 1'b1;
            m_done = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (n >= 0) begin
         check("y_valid", 32'(bus.y_valid), 32'(e_v[n]));
         if (e_v[n]) check("y", bus.y, e_y[n]);
         check("lut_active", 32'(bus.lut_active), 32'(m_active));
         check("lut_swap_done", 32'(bus.lut_swap_done), 32'(m_done));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input string name, input logic [31:0] x, input logic [9:0] a,
                        input logic en, input logic [31:0] exp_y);
      int lat;
      bus.mag = a; bus.lut_enable = en; bus.tu = x; bus.tu_valid = 1'b1;
      tick();
      bus.tu_valid = 1'b0; bus.tu = '0;
      lat = 0;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if (bus.y_valid) begin lat = k; break; end
      end
      check($sformatf("%s latency", name), 32'(lat), 32'(ML + 4));
      check($sformatf("%s y", name), bus.y, exp_y);
      tick();
   endtask

   task automatic lut_write(input logic [9:0] a, input logic [31:0] d);
      bus.lut_wr_en = 1'b1; bus.lut_wr_addr = a; bus.lut_wr_data = d;
      tick();
      bus.lut_wr_en = 1'b0;
   endtask

   task automatic do_swap(input string name, input logic exp_active);
      int lat;
      bus.lut_swap_req = 1'b1;
      tick();
      bus.lut_swap_req = 1'b0;
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (bus.lut_swap_done) begin lat = k; break; end
      end
      check($sformatf("%s done latency", name), 32'(lat), 32'd2);
      check($sformatf("%s active", name), 32'(bus.lut_active), 32'(exp_active));
      tick();
   endtask

   task automatic random_run(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         bus.tu           = $urandom;
         bus.tu_valid     = ($urandom_range(0, 9) < 7);
         bus.mag          = 10'($urandom_range(0, 15));
         bus.lut_enable   = ($urandom_range(0, 9) != 0);
         bus.lut_wr_en    = ($urandom_range(0, 4) == 0);
         bus.lut_wr_addr  = 10'($urandom_range(8, 15));
         bus.lut_wr_data  = $urandom;
         bus.lut_swap_req = ($urandom_range(0, 29) == 0);
         tick();
      end
      bus.tu_valid = 1'b0; bus.lut_wr_en = 1'b0; bus.lut_swap_req = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      int cnt;
      rst = 1'b1;
      bus.tu = '0; bus.tu_valid = 1'b0; bus.mag = '0; bus.lut_enable = 1'b0;
      bus.lut_wr_en = 1'b0; bus.lut_wr_addr = '0; bus.lut_wr_data = '0; bus.lut_swap_req = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("reset y", bus.y, 32'h0);
      check("reset y_valid", 32'(bus.y_valid), 32'h0);
      check("reset lut_active", 32'(bus.lut_active), 32'h0);
      check("reset swap_done", 32'(bus.lut_swap_done), 32'h0);
      tick();
      rst = 1'b0;
      tick();

      probe("T1 bypass", 32'h03E8_FE0C, 10'd0, 1'b0, 32'h03E8_FE0C);

      for (int i = 0; i < 16; i++)
         lut_write(10'(i), (i == 5) ? 32'h2000_0000 : (i == 6) ? 32'h0000_4000 :
                           (i == 7) ? 32'h7FFF_0000 : 32'h4000_0000);
      do_swap("init swap", 1'b1);
      for (int i = 0; i < 16; i++)
         lut_write(10'(i), (i == 5) ? 32'h1000_0000 : 32'h4000_0000);

      probe("T2 gain", 32'h07D0_07D0, 10'd5, 1'b1, 32'h03E8_03E8);
      probe("T3 rotation", 32'h0001_0000, 10'd6, 1'b1, 32'h0000_0001);
      probe("T3 saturation", 32'h7FFF_0000, 10'd7, 1'b1, 32'h7FFF_0000);
      probe("T4 round pos", 32'h0003_0000, 10'd5, 1'b1, 32'h0002_0000);
      probe("T4 round neg", 32'hFFFD_0000, 10'd5, 1'b1, 32'hFFFF_0000);

      // T5: swap requested in the middle of an 8-write burst, samples streaming
      bus.lut_enable = 1'b1; bus.mag = 10'd8;
      for (int i = 0; i < 8; i++) begin
         bus.lut_wr_en = 1'b1; bus.lut_wr_addr = 10'(8 + i); bus.lut_wr_data = $urandom;
         bus.lut_swap_req = (i == 3);
         bus.tu = $urandom; bus.tu_valid = 1'b1;
         tick();
      end
      bus.lut_wr_en = 1'b0; bus.lut_swap_req = 1'b0;
      @(negedge clk);
      check("T5 done during pend", 32'(bus.lut_swap_done), 32'h0);
      @(negedge clk);
      check("T5 done after burst", 32'(bus.lut_swap_done), 32'h1);
      check("T5 active toggled", 32'(bus.lut_active), 32'h0);
      @(negedge clk);
      check("T5 done single pulse", 32'(bus.lut_swap_done), 32'h0);
      tick();
      bus.tu_valid = 1'b0;
      repeat (ML + 6) tick();

      random_run(1500);

      // T6: reset while samples are in flight and a swap is pending behind a burst
      bus.lut_enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.tu = $urandom; bus.tu_valid = 1'b1; bus.mag = 10'($urandom_range(0, 15));
         bus.lut_wr_en = 1'b1; bus.lut_wr_addr = 10'(8 + i); bus.lut_wr_data = $urandom;
         bus.lut_swap_req = (i == 0);
         tick();
      end
      bus.lut_swap_req = 1'b0; bus.lut_wr_en = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0; bus.tu_valid = 1'b0;
      @(negedge clk);
      check("T6 y", bus.y, 32'h0);
      check("T6 y_valid", 32'(bus.y_valid), 32'h0);
      check("T6 lut_active", 32'(bus.lut_active), 32'h0);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.lut_swap_done) cnt++;
      end
      check("T6 no swap_done", 32'(cnt), 32'h0);
      tick();
      probe("T6 lut kept", 32'h07D0_07D0, 10'd5, 1'b1, 32'h01F4_01F4);

      random_run(300);
      repeat (ML + 10) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
